// File: rtl/cross_bar_pkg.sv
// Shared crossbar sizing defaults.
package cross_bar_pkg;
    localparam int unsigned MASTER_N = 4;
    localparam int unsigned DATA_W   = 32;
endpackage

// File: rtl/cross_bar_slave_resp.sv
// Slave-side response router: tracks which master issued each accepted read
// and steers in-order read responses back to that master one cycle later.
module cross_bar_slave_resp #(
    parameter int unsigned MASTER_N = cross_bar_pkg::MASTER_N,
    parameter int unsigned DATA_W   = cross_bar_pkg::DATA_W,
    parameter int unsigned OUTST_N  = 4
) (
    input  logic                                clk,
    input  logic                                areset,
    input  logic [MASTER_N-1:0]                 mgrant,
    input  logic                                slave_req,
    input  logic                                slave_cmd,
    input  logic                                slave_ack,
    input  logic                                slave_resp,
    input  logic [DATA_W-1:0]                   slave_rdata,
    output logic [MASTER_N-1:0]                 master_ack,
    output logic [MASTER_N-1:0]                 master_resp,
    output logic [MASTER_N-1:0][DATA_W-1:0]     master_rdata,
    output logic                                rd_full,
    output logic [$clog2(OUTST_N+1)-1:0]        outst_cnt,
    output logic                                resp_err
);

    localparam int unsigned CNT_W = $clog2(OUTST_N + 1);
    localparam int unsigned PTR_W = $clog2(OUTST_N);
    localparam int unsigned IDX_W = (MASTER_N > 1) ? $clog2(MASTER_N) : 1;

    logic                hs;
    logic                rd_hs;
    logic                wr_hs;
    logic                pop;
    logic                push_ok;
    logic                push;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    pop_idx;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    cnt_next;
    logic [MASTER_N-1:0] resp_next;
    logic                err_next;
    logic [IDX_W-1:0]    fifo [OUTST_N];

    assign hs      = slave_req & slave_ack;
    assign rd_hs   = hs & ~slave_cmd;
    assign wr_hs   = hs & slave_cmd;
    assign pop     = slave_resp & (outst_cnt != '0);
    // A same-cycle pop frees a slot, so a full tracker can still accept.
    assign push_ok = (outst_cnt < CNT_W'(OUTST_N)) | pop;
    assign push    = rd_hs & push_ok;
    assign pop_idx = fifo[rd_ptr];

    assign master_ack = mgrant & {MASTER_N{wr_hs | (rd_hs & push_ok)}};

    // One-hot grant to binary master index.
    always_comb begin
        grant_idx = '0;
        for (int unsigned m = 0; m < MASTER_N; m++) begin
            if (mgrant[m]) begin
                grant_idx = grant_idx | IDX_W'(m);
            end
        end
    end

    always_comb begin
        cnt_next  = outst_cnt;
        resp_next = '0;
        err_next  = resp_err | (slave_resp & (outst_cnt == '0));
        if (push & ~pop) begin
            cnt_next = outst_cnt + CNT_W'(1);
        end else if (pop & ~push) begin
            cnt_next = outst_cnt - CNT_W'(1);
        end
        for (int unsigned m = 0; m < MASTER_N; m++) begin
            resp_next[m] = pop & (pop_idx == IDX_W'(m));
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            outst_cnt    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_full      <= 1'b0;
            master_resp  <= '0;
            master_rdata <= '0;
            resp_err     <= 1'b0;
        end else begin
            outst_cnt   <= cnt_next;
            wr_ptr      <= wr_ptr + PTR_W'(push);
            rd_ptr      <= rd_ptr + PTR_W'(pop);
            rd_full     <= (cnt_next == CNT_W'(OUTST_N));
            master_resp <= resp_next;
            resp_err    <= err_next;
            for (int unsigned m = 0; m < MASTER_N; m++) begin
                if (resp_next[m]) begin
                    master_rdata[m] <= slave_rdata;
                end
            end
        end
    end

    // Tracker storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= grant_idx;
        end
    end

endmodule

// File: tb/tb_cross_bar_slave_resp.sv
// Scoreboard bench for cross_bar_slave_resp: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_cross_bar_slave_resp;

    localparam int unsigned MN = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned ON = 4;

    logic                   clk = 1'b0;
    logic                   areset = 1'b1;
    logic [MN-1:0]          mgrant = '0;
    logic                   slave_req = 1'b0;
    logic                   slave_cmd = 1'b0;
    logic                   slave_ack = 1'b0;
    logic                   slave_resp = 1'b0;
    logic [DW-1:0]          slave_rdata = '0;
    logic [MN-1:0]          master_ack;
    logic [MN-1:0]          master_resp;
    logic [MN-1:0][DW-1:0]  master_rdata;
    logic                   rd_full;
    logic [2:0]             outst_cnt;
    logic                   resp_err;

    cross_bar_slave_resp #(.MASTER_N(MN), .DATA_W(DW), .OUTST_N(ON)) dut (
        .clk(clk), .areset(areset), .mgrant(mgrant),
        .slave_req(slave_req), .slave_cmd(slave_cmd), .slave_ack(slave_ack),
        .slave_resp(slave_resp), .slave_rdata(slave_rdata),
        .master_ack(master_ack), .master_resp(master_resp),
        .master_rdata(master_rdata), .rd_full(rd_full),
        .outst_cnt(outst_cnt), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          idx;
        logic [31:0] data;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          edge_n = 0;
    int          mq[$];          // master index of each outstanding read, oldest first
    exp_t        exp_q[$];       // expected response strobes with due edge
    logic        exp_err = 1'b0;
    logic [31:0] shadow [MN];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [MN-1:0] g);
        int r = 0;
        for (int i = 0; i < int'(MN); i++) if (g[i]) r = i;
        return r;
    endfunction

    // One bus cycle: drive at negedge, check combinational ack, advance model.
    task automatic step(input logic rst, input logic [MN-1:0] g, input logic req,
                        input logic cmd, input logic ack, input logic resp,
                        input logic [31:0] d);
        logic pop_m, push_ok, rd, wr;
        logic [MN-1:0] exp_ack;
        exp_t e;
        @(negedge clk);
        areset = rst; mgrant = g; slave_req = req; slave_cmd = cmd;
        slave_ack = ack; slave_resp = resp; slave_rdata = d;
        if (rst) begin
            mq.delete(); exp_q.delete(); exp_err = 1'b0;
            for (int i = 0; i < int'(MN); i++) shadow[i] = '0;
        end
        assert (!(req && ack) || $onehot(g)) else $error("grant not one-hot during handshake");
        #1;
        pop_m   = resp && (mq.size() != 0);
        push_ok = (mq.size() < int'(ON)) || pop_m;
        rd      = req && ack && !cmd;
        wr      = req && ack && cmd;
        exp_ack = (wr || (rd && push_ok)) ? g : '0;
        chk("master_ack", 64'(master_ack), 64'(exp_ack));
        if (!rst) begin
            if (resp && mq.size() == 0) exp_err = 1'b1;
            if (pop_m) begin
                e.idx  = mq.pop_front();
                e.data = d;
                e.cyc  = edge_n + 1;
                exp_q.push_back(e);
            end
            if (rd && push_ok) mq.push_back(idx_of(g));
        end
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic rd_req(input int m);
        step(1'b0, MN'(1 << m), 1'b1, 1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic rsp(input logic [31:0] d);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    // Monitor: after each rising edge compare registered outputs to the model.
    always @(posedge clk) begin
        logic [MN-1:0] er;
        exp_t e;
        edge_n++;
        #2;
        er = '0;
        if (exp_q.size() != 0 && exp_q[0].cyc == edge_n) begin
            e = exp_q.pop_front();
            er[e.idx] = 1'b1;
            shadow[e.idx] = e.data;
        end
        chk("master_resp", 64'(master_resp), 64'(er));
        for (int i = 0; i < int'(MN); i++) chk("master_rdata", 64'(master_rdata[i]), 64'(shadow[i]));
        chk("outst_cnt", 64'(outst_cnt), 64'(mq.size()));
        chk("rd_full", 64'(rd_full), 64'(mq.size() == int'(ON)));
        chk("resp_err", 64'(resp_err), 64'(exp_err));
    end

    initial begin
        int m;
        logic r;
        for (int i = 0; i < int'(MN); i++) shadow[i] = '0;

        // Reset; a read handshake during reset is acked but not tracked.
        step(1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle();

        // Single read with 3-cycle slave latency.
        step(1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        idle(); idle();
        rsp(32'hA5A5_0001);
        idle(); idle();

        // Ordering across masters, back-to-back responses.
        rd_req(2); rd_req(0); rd_req(3);
        rsp(32'hD000_0000); rsp(32'hD111_1111); rsp(32'hD222_2222);
        idle(); idle();

        // Fill the tracker, reject, then accept alongside a pop.
        rd_req(0); rd_req(1); rd_req(2); rd_req(3);
        idle();
        rd_req(1);
        step(1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1234_5678);
        rsp(32'h0000_0011); rsp(32'h0000_0022); rsp(32'h0000_0033); rsp(32'h0000_0044);
        idle();

        // Write: acked, not tracked.
        step(1'b0, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        rd_req(1);
        step(1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        rsp(32'hCAFE_F00D);
        idle();

        // Reset mid-flight, then a response with nothing outstanding.
        rd_req(0); rd_req(3);
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle();
        rsp(32'hDEAD_BEEF);
        idle(); idle();
        rsp(32'hDEAD_BEEF);
        idle();
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle();

        // Randomized traffic with in-order responses only when reads are pending.
        for (int n = 0; n < 400; n++) begin
            m = int'($urandom_range(0, MN - 1));
            r = (mq.size() != 0) ? 1'($urandom % 2) : 1'b0;
            step(1'b0, MN'(1 << m), 1'($urandom % 2), 1'($urandom % 3 == 0),
                 1'($urandom % 2), r, $urandom);
        end
        while (mq.size() != 0) rsp($urandom);
        idle(); idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
